rca_32bit: RTL and testbench
============================

Name: rca_32bit

Overview:
- 32-bit ripple-carry adder built as a linear chain of 1-bit full adders.
- Computes {Cout, Sum} = A + B + Cin combinationally, with zero latency.
- Also provides a registered copy of the result for pipelined consumers, clocked on clk and cleared by synchronous active-high rst.
- Serves as the wide-add building block in the 64-bit Vedic multiplier's partial-product summation.

Parameters:
- WIDTH, 32, operand/sum width in bits. Only 32 is verified; the RTL must remain generic.

Ports:
- clk  input  1  system clock; the only clock; registered outputs update on its rising edge.
- rst  input  1  synchronous, active-high reset; clears the registered outputs only.
- A  input  WIDTH  addend, unsigned.
- B  input  WIDTH  addend, unsigned.
- Cin  input  1  carry into bit 0.
- Sum  output  WIDTH  combinational sum bits, (A+B+Cin) mod 2^WIDTH.
- Cout  output  1  combinational carry out of bit WIDTH-1.
- Sum_q  output  WIDTH  Sum registered on clk.
- Cout_q  output  1  Cout registered on clk.

Behaviour:
- Combinational path:
  - Sum/Cout depend only on A, B and Cin, with no clock involvement. They are valid after ripple settle, with no timing-unit delays in the RTL.
  - Bit i: s[i] = A[i] ^ B[i] ^ c[i].
  - Carry: c[i+1] = (A[i]&B[i]) | (c[i]&(A[i]^B[i])), with c[0] = Cin and Cout = c[WIDTH].
  - Carry must physically ripple through WIDTH full-adder instances. No lookahead, no behavioural "+" operator.
  - Sum/Cout are unaffected by rst and respond to input changes while rst is high.
- Unsigned semantics:
  - Overflow is reported only via Cout; Sum wraps modulo 2^WIDTH.
  - No signed-overflow flag.
- Registered path:
  - On each rising clk: if rst = 1, Sum_q <= 0 and Cout_q <= 0; else Sum_q <= Sum and Cout_q <= Cout.
  - Latency is exactly 1 cycle from inputs sampled at an edge to Sum_q/Cout_q.
  - No enable and no handshake: registered outputs update every cycle.
  - Registered outputs are undefined (X) before the first clock edge with rst asserted. After reset, the 0/0 value holds until the first non-reset edge.
  - Reset asserted mid-stream: the next edge clears the registers regardless of inputs. Deasserting reset resumes capture on the following edge.
- Boundary cases:
  - All-ones + 0 + Cin=1 → Sum = 0, Cout = 1 (full-length carry propagation).
  - All-ones + all-ones + 1 → Sum = all-ones, Cout = 1.
  - 0 + 0 + 0 → Sum = 0, Cout = 0.
- Inputs X/Z: no special handling.

Decomposition:
- No shared package is needed. WIDTH stays a local parameter; no typedefs.
- One sub-module, full_adder:
  - ports a, b, cin → s, cout;
  - purely combinational;
  - WIDTH instances in a generate loop chained through an internal carry vector c[WIDTH:0].
- Output registers live in the rca_32bit top.

Test Plan:
- Zero / low values: A=0, B=0, Cin=0 → Sum=0, Cout=0. Then A=1, B=2, Cin=1 → Sum=4, Cout=0, both combinationally.
- Counting sweep: A increments every 4 ns from 0, B every 2 ns, Cin toggles every 1 ns, for 100 ns. Every sample must satisfy {Cout, Sum} == A+B+Cin; e.g. A=3, B=6, Cin=1 → Sum=10.
- Full carry ripple: A=0xFFFFFFFF, B=0, Cin=1 → Sum=0x00000000, Cout=1. Same A and B with Cin=0 → Sum=0xFFFFFFFF, Cout=0.
- Max operands: A=B=0xFFFFFFFF, Cin=1 → Sum=0xFFFFFFFF, Cout=1. A=0x80000000, B=0x80000000, Cin=0 → Sum=0, Cout=1.
- Registered path and reset:
  - Hold rst=1 for 2 edges → Sum_q=0, Cout_q=0, while Sum reflects live inputs (A=5, B=7 → Sum=12).
  - Release rst → after 1 edge, Sum_q=12.
  - Assert rst mid-stream → next edge clears Sum_q/Cout_q to 0.
- Random check: 10,000 random A/B/Cin vectors, each compared against a reference 33-bit add; Sum_q/Cout_q match the previous cycle's reference.

Source files
------------

// File: rtl/rca_32bit_if.sv
// rca_32bit_if: bundles the adder's operand and result signals so a consumer
// can pass them around as one object.
//   master : drives A, B, Cin; observes Sum, Cout, Sum_q, Cout_q
//   slave  : the adder side of the same signals
// clk and rst are not part of the bundle.
`timescale 1ns/1ps
interface rca_32bit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic [WIDTH-1:0] Sum_q;
  logic             Cout_q;

  modport master (
    output A, B, Cin,
    input  Sum, Cout, Sum_q, Cout_q
  );

  modport slave (
    input  A, B, Cin,
    output Sum, Cout, Sum_q, Cout_q
  );
endinterface

// File: rtl/rca_32bit_full_adder.sv
// full_adder: single-bit full adder, purely combinational.
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out (generate, or propagate of the incoming carry)
`timescale 1ns/1ps
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/rca_32bit.sv
// rca_32bit: WIDTH-bit ripple-carry adder, {Cout, Sum} = A + B + Cin, built
// from a chain of full_adder cells, plus a registered copy of the result.
//   clk    : clock, registered outputs update on rising edge
//   rst    : synchronous active-high reset, clears Sum_q/Cout_q only
//   A, B   : unsigned addends
//   Cin    : carry into bit 0
//   Sum    : combinational sum, wraps modulo 2^WIDTH
//   Cout   : combinational carry out of the top bit
//   Sum_q  : Sum registered on clk
//   Cout_q : Cout registered on clk
`timescale 1ns/1ps
module rca_32bit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic [WIDTH-1:0] Sum_q,
  output logic             Cout_q
);
  // c[i] is the carry into bit i; c[WIDTH] is the final carry out.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (c[i]),
      .s    (Sum[i]),
      .cout (c[i+1])
    );
  end

  assign Cout   = c[WIDTH];
  assign sum_d  = Sum;
  assign cout_d = Cout;

  always_ff @(posedge clk) begin
    if (rst) begin
      Sum_q  <= '0;
      Cout_q <= 1'b0;
    end else begin
      Sum_q  <= sum_d;
      Cout_q <= cout_d;
    end
  end
endmodule

// File: tb/tb_rca_32bit.sv
`timescale 1ns/1ps
module tb_rca_32bit;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  rca_32bit_if #(.WIDTH(W)) bus ();

  rca_32bit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .A      (bus.A),
    .B      (bus.B),
    .Cin    (bus.Cin),
    .Sum    (bus.Sum),
    .Cout   (bus.Cout),
    .Sum_q  (bus.Sum_q),
    .Cout_q (bus.Cout_q)
  );

  always #5 clk = ~clk;

  // Reference: plain 33-bit arithmetic.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Registered-path model: what Sum_q/Cout_q must hold after each edge.
  logic [W:0] model_q;
  bit         chk_c_en = 1'b0;
  bit         chk_q_en = 1'b0;

  always @(posedge clk) begin
    if (rst) model_q = '0;
    else     model_q = ref_add(bus.A, bus.B, bus.Cin);
  end

  // Compare process: mid-cycle, inputs stable since posedge+1.
  always @(negedge clk) begin
    logic [W:0] e;
    if (chk_c_en) begin
      e = ref_add(bus.A, bus.B, bus.Cin);
      chk("comb_sum",  64'(bus.Sum),  64'(e[W-1:0]));
      chk("comb_cout", 64'(bus.Cout), 64'(e[W]));
    end
    if (chk_q_en) begin
      chk("reg_sum",  64'(bus.Sum_q),  64'(model_q[W-1:0]));
      chk("reg_cout", 64'(bus.Cout_q), 64'(model_q[W]));
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    bus.A   = a;
    bus.B   = b;
    bus.Cin = ci;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t dir [7];

  initial begin
    dir[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    dir[1] = '{32'h0000_0001, 32'h0000_0002, 1'b1, 32'h0000_0004, 1'b0};
    dir[2] = '{32'h0000_0003, 32'h0000_0006, 1'b1, 32'h0000_000A, 1'b0};
    dir[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    dir[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0};
    dir[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    dir[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};

    // Reset held for two edges; combinational path stays live.
    rst = 1'b1;
    drive(32'd5, 32'd7, 1'b0);
    chk_c_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_q_en = 1'b1;
    chk("rst_sum_q",   64'(bus.Sum_q),  64'd0);
    chk("rst_cout_q",  64'(bus.Cout_q), 64'd0);
    chk("rst_sum_live", 64'(bus.Sum),   64'd12);

    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("release_sum_q",  64'(bus.Sum_q),  64'd12);
    chk("release_cout_q", 64'(bus.Cout_q), 64'd0);

    // Directed vectors with hand-computed results.
    foreach (dir[i]) begin
      @(posedge clk);
      #1;
      drive(dir[i].a, dir[i].b, dir[i].ci);
      #1;
      chk($sformatf("dir%0d_sum", i),  64'(bus.Sum),  64'(dir[i].s));
      chk($sformatf("dir%0d_cout", i), 64'(bus.Cout), 64'(dir[i].co));
    end

    // Reset asserted mid-stream with a carry-producing input.
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    @(posedge clk);
    #1;
    chk("mid_rst_sum_q",  64'(bus.Sum_q),  64'd0);
    chk("mid_rst_cout_q", 64'(bus.Cout_q), 64'd0);
    chk("mid_rst_sum",    64'(bus.Sum),    64'd0);
    chk("mid_rst_cout",   64'(bus.Cout),   64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("resume_sum_q",  64'(bus.Sum_q),  64'd0);
    chk("resume_cout_q", 64'(bus.Cout_q), 64'd1);

    // Counting sweep, asynchronous to clk: registered checks paused.
    chk_c_en = 1'b0;
    chk_q_en = 1'b0;
    for (int t = 0; t < 100; t++) begin
      logic [W:0] e;
      drive(W'(t / 4), W'(t / 2), 1'(t % 2));
      #0.5;
      e = ref_add(W'(t / 4), W'(t / 2), 1'(t % 2));
      chk("sweep_sum",  64'(bus.Sum),  64'(e[W-1:0]));
      chk("sweep_cout", 64'(bus.Cout), 64'(e[W]));
      #0.5;
    end

    // Realign to the clock before resuming per-cycle checks.
    @(posedge clk);
    #1;
    drive($urandom, $urandom, 1'($urandom));
    chk_c_en = 1'b1;
    @(posedge clk);
    #1;
    chk_q_en = 1'b1;

    // Random vectors, one per cycle.
    for (int n = 0; n < 10000; n++) begin
      drive($urandom, $urandom, 1'($urandom));
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, time %0t expected < 2ms", $time);
    $fatal(1);
  end
endmodule
